uart_rx_core: RTL

//  UART receiver driven by the 16x rx_clk tick from the baud clock generator.
//  - Synchronises the serial line and detects start bits, sampling each bit at mid-bit.
//  - Deframes LSB-first data into a one-entry holding register with a valid/ready handshake.
//  - Sits between the pad and the APB UART register block.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_core.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, reset value selectable.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver with one-entry holding register and valid/ready output.
// Optional parity bit checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_core: unsupported parameter combination");
  end

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx_serial),
    .q_o    (rx_s)
  );

  rx_state_t              state_q, state_d;
  logic                   armed_q, armed_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   stop_q, stop_d;
  logic                   load_q, load_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop_q     <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      stop_q     <= stop_d;
      load_q     <= load_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      pe_q       <= pe_d;
`endif
    end
  end

  // Frame sequencer: every action is gated by rx_tick; armed_q keeps a held-low
  // line (break or bad stop) from being mistaken for a fresh start bit.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_d     = stop_q;
    load_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (rx_tick) begin
      unique case (state_q)
        IDLE: begin
          if (armed_q && !rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
            armed_d    = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
        START: begin
          if (tick_cnt_q == TICK_HALF) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            par_d      = rx_s;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            stop_d     = rx_s;
            load_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake clears first; a simultaneous load then refills, so a consumed word
  // never counts as overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
`endif
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      fe_d    = ~stop_q;
      ovr_d   = ovr_d | (valid_q & ~rx_ready);
`ifdef UART_RX_PARITY_EN
      pe_d    = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = fe_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
